// File: rtl/fetch_stage_reg.sv
// Pre-IF -> IF pipeline register: lane payload, stale-response cancel counter and one-entry instruction buffer.
// Optional `FETCH_DISCARD_STAT_EN adds a 32-bit discarded-response counter (discard_total_o).
module fetch_stage_reg #(
  parameter int                LANES      = 2,
  parameter int                PC_W       = 32,
  parameter int                EXC_W      = 7,
  parameter int                INST_W     = 32,
  parameter int                PR_W       = 64,
  parameter int                MAX_CANCEL = 3,
  parameter logic [PC_W-1:0]   RESET_PC   = 32'h1c000000,
  localparam int               CNT_W      = $clog2(MAX_CANCEL + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    preif_valid_i,
  input  logic                    if_allowin_i,
  output logic                    if_valid_o,
  input  logic                    excep_flush_i,
  input  logic                    branch_flush_i,
  input  logic                    req_i,
  output logic                    req_o,
  input  logic [LANES*PC_W-1:0]   pc_i,
  output logic [LANES*PC_W-1:0]   pc_o,
  input  logic [LANES-1:0]        exc_en_i,
  output logic [LANES-1:0]        exc_en_o,
  input  logic [LANES*EXC_W-1:0]  exc_type_i,
  output logic [LANES*EXC_W-1:0]  exc_type_o,
  input  logic                    pr_we_i,
  input  logic [PR_W-1:0]         pr_data_i,
  output logic [PR_W-1:0]         pr_data_o,
  input  logic                    cancel_inc_i,
  input  logic                    resp_valid_i,
  input  logic [LANES*INST_W-1:0] resp_data_i,
  output logic                    resp_discard_o,
  output logic [CNT_W-1:0]        cancel_cnt_o,
  output logic                    cancel_ovf_o,
  input  logic                    buf_hold_i,
  input  logic                    buf_take_i,
  output logic                    inst_buf_valid_o,
`ifdef FETCH_DISCARD_STAT_EN
  output logic [31:0]             discard_total_o,
`endif
  output logic [LANES*INST_W-1:0] inst_buf_data_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CANCEL);

  function automatic logic [LANES*PC_W-1:0] reset_pcs();
    logic [LANES*PC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PC_W +: PC_W] = RESET_PC + PC_W'(4 * i);
    return r;
  endfunction

  localparam logic [LANES*PC_W-1:0] PC_RST = reset_pcs();

  logic             load;
  logic             flush;
  logic             buf_clear;
  logic             buf_load;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_set;

  assign load           = preif_valid_i && if_allowin_i;
  assign flush          = excep_flush_i || branch_flush_i;
  assign resp_discard_o = resp_valid_i && (cancel_cnt_o != '0);
  assign buf_clear      = buf_take_i || flush;
  assign buf_load       = resp_valid_i && !resp_discard_o && buf_hold_i && !inst_buf_valid_o;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_nxt = cancel_cnt_o;
    ovf_set = 1'b0;
    if (cancel_inc_i && !resp_discard_o) begin
      if (cancel_cnt_o == CNT_MAX) ovf_set = 1'b1;
      else                         cnt_nxt = cancel_cnt_o + CNT_W'(1);
    end else if (!cancel_inc_i && resp_discard_o) begin
      cnt_nxt = cancel_cnt_o - CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_o             <= PC_RST;
      exc_en_o         <= '0;
      exc_type_o       <= '0;
      req_o            <= 1'b0;
      if_valid_o       <= 1'b0;
      pr_data_o        <= '0;
      cancel_cnt_o     <= '0;
      cancel_ovf_o     <= 1'b0;
      inst_buf_valid_o <= 1'b0;
      // NOTE: buffer data is reset only because it is visible on a port; a pure datapath register would skip it.
      inst_buf_data_o  <= '0;
    end else begin
      if (load) begin
        pc_o       <= pc_i;
        exc_en_o   <= exc_en_i;
        exc_type_o <= exc_type_i;
        req_o      <= req_i;
      end
      if (flush)             if_valid_o <= 1'b0;
      else if (if_allowin_i) if_valid_o <= preif_valid_i;
      if (pr_we_i) pr_data_o <= pr_data_i;
      cancel_cnt_o <= cnt_nxt;
      if (ovf_set) cancel_ovf_o <= 1'b1;
      // Clear beats load; a full buffer ignores further responses.
      if (buf_clear) begin
        inst_buf_valid_o <= 1'b0;
      end else if (buf_load) begin
        inst_buf_valid_o <= 1'b1;
        inst_buf_data_o  <= resp_data_i;
      end
    end
  end

`ifdef FETCH_DISCARD_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)              discard_total_o <= '0;
    else if (resp_discard_o) discard_total_o <= discard_total_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage_reg.sv
// Bench for fetch_stage_reg: directed plan checks plus randomized traffic against a behavioural model.
module tb_fetch_stage_reg;
  localparam int LANES = 2, PC_W = 32, EXC_W = 7, INST_W = 32, PR_W = 64, MAX_CANCEL = 3;
  localparam int CNT_W = $clog2(MAX_CANCEL + 1);
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic clk = 1'b0;
  logic rst_n, preif_valid_i, if_allowin_i, if_valid_o, excep_flush_i, branch_flush_i;
  logic req_i, req_o, pr_we_i, cancel_inc_i, resp_valid_i, resp_discard_o, cancel_ovf_o;
  logic buf_hold_i, buf_take_i, inst_buf_valid_o;
  logic [LANES*PC_W-1:0]   pc_i, pc_o;
  logic [LANES-1:0]        exc_en_i, exc_en_o;
  logic [LANES*EXC_W-1:0]  exc_type_i, exc_type_o;
  logic [PR_W-1:0]         pr_data_i, pr_data_o;
  logic [LANES*INST_W-1:0] resp_data_i, inst_buf_data_o;
  logic [CNT_W-1:0]        cancel_cnt_o;
`ifdef FETCH_DISCARD_STAT_EN
  logic [31:0]             discard_total_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  fetch_stage_reg #(.LANES(LANES), .PC_W(PC_W), .EXC_W(EXC_W), .INST_W(INST_W), .PR_W(PR_W),
                    .MAX_CANCEL(MAX_CANCEL), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .preif_valid_i(preif_valid_i), .if_allowin_i(if_allowin_i),
    .if_valid_o(if_valid_o), .excep_flush_i(excep_flush_i), .branch_flush_i(branch_flush_i),
    .req_i(req_i), .req_o(req_o), .pc_i(pc_i), .pc_o(pc_o), .exc_en_i(exc_en_i), .exc_en_o(exc_en_o),
    .exc_type_i(exc_type_i), .exc_type_o(exc_type_o), .pr_we_i(pr_we_i), .pr_data_i(pr_data_i),
    .pr_data_o(pr_data_o), .cancel_inc_i(cancel_inc_i), .resp_valid_i(resp_valid_i),
    .resp_data_i(resp_data_i), .resp_discard_o(resp_discard_o), .cancel_cnt_o(cancel_cnt_o),
    .cancel_ovf_o(cancel_ovf_o), .buf_hold_i(buf_hold_i), .buf_take_i(buf_take_i),
    .inst_buf_valid_o(inst_buf_valid_o),
`ifdef FETCH_DISCARD_STAT_EN
    .discard_total_o(discard_total_o),
`endif
    .inst_buf_data_o(inst_buf_data_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers and vectors, updated once per rising edge.
  logic [LANES*PC_W-1:0]   m_pc;
  logic [LANES-1:0]        m_exc_en;
  logic [LANES*EXC_W-1:0]  m_exc_type;
  logic                    m_req, m_valid, m_ovf, m_buf_valid;
  logic [PR_W-1:0]         m_pr;
  logic [LANES*INST_W-1:0] m_buf_data;
  int                      m_cnt;
  longint                  m_total;

  always @(posedge clk) begin
    bit disc;
    disc = resp_valid_i && (m_cnt > 0);
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) m_pc[i*PC_W +: PC_W] = RESET_PC + 4 * i;
      m_exc_en = '0; m_exc_type = '0; m_req = 0; m_valid = 0; m_pr = '0;
      m_cnt = 0; m_ovf = 0; m_buf_valid = 0; m_buf_data = '0; m_total = 0;
    end else begin
      if (preif_valid_i && if_allowin_i) begin
        m_pc = pc_i; m_exc_en = exc_en_i; m_exc_type = exc_type_i; m_req = req_i;
      end
      if (excep_flush_i || branch_flush_i) m_valid = 0;
      else if (if_allowin_i)               m_valid = preif_valid_i;
      if (pr_we_i) m_pr = pr_data_i;
      m_cnt = m_cnt + int'(cancel_inc_i) - int'(disc);
      if (m_cnt > MAX_CANCEL) begin
        m_cnt = MAX_CANCEL;
        m_ovf = 1;
      end
      if (buf_take_i || excep_flush_i || branch_flush_i) m_buf_valid = 0;
      else if (resp_valid_i && !disc && buf_hold_i && !m_buf_valid) begin
        m_buf_valid = 1; m_buf_data = resp_data_i;
      end
      if (disc) m_total = (m_total + 1) % (64'd1 << 32);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc_o, m_pc);
      check("exc_en", 64'(exc_en_o), 64'(m_exc_en));
      check("exc_type", 64'(exc_type_o), 64'(m_exc_type));
      check("req", 64'(req_o), 64'(m_req));
      check("if_valid", 64'(if_valid_o), 64'(m_valid));
      check("pr_data", pr_data_o, m_pr);
      check("cancel_cnt", 64'(cancel_cnt_o), 64'(m_cnt));
      check("cancel_ovf", 64'(cancel_ovf_o), 64'(m_ovf));
      check("discard", 64'(resp_discard_o), 64'(resp_valid_i && (m_cnt > 0)));
      check("buf_valid", 64'(inst_buf_valid_o), 64'(m_buf_valid));
      if (m_buf_valid) check("buf_data", inst_buf_data_o, m_buf_data);
`ifdef FETCH_DISCARD_STAT_EN
      check("discard_total", 64'(discard_total_o), 64'(m_total));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    preif_valid_i = 0; if_allowin_i = 0; excep_flush_i = 0; branch_flush_i = 0; req_i = 0;
    pc_i = '0; exc_en_i = '0; exc_type_i = '0; pr_we_i = 0; pr_data_i = '0;
    cancel_inc_i = 0; resp_valid_i = 0; resp_data_i = '0; buf_hold_i = 0; buf_take_i = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    chk_en = 1;
    check("rst_pc", pc_o, 64'h1c000004_1c000000);
    check("rst_if_valid", 64'(if_valid_o), 64'd0);
    check("rst_cnt", 64'(cancel_cnt_o), 64'd0);
    check("rst_buf_valid", 64'(inst_buf_valid_o), 64'd0);

    // Handshake, hold, flush
    preif_valid_i = 1; if_allowin_i = 1; pc_i = 64'h1c000014_1c000010;
    step();
    check("load_pc", pc_o, 64'h1c000014_1c000010);
    check("load_valid", 64'(if_valid_o), 64'd1);
    if_allowin_i = 0; pc_i = 64'h1c000024_1c000020;
    step();
    check("hold_pc", pc_o, 64'h1c000014_1c000010);
    idle();
    branch_flush_i = 1;
    step();
    branch_flush_i = 0;
    check("flush_valid", 64'(if_valid_o), 64'd0);
    check("flush_pc", pc_o, 64'h1c000014_1c000010);

    // Cancel counting: 2 increments, then 3 responses
    cancel_inc_i = 1;
    step(); step();
    cancel_inc_i = 0;
    check("cnt_two", 64'(cancel_cnt_o), 64'd2);
    resp_valid_i = 1;
    #1 check("disc_a", 64'(resp_discard_o), 64'd1);
    step();
    check("cnt_one", 64'(cancel_cnt_o), 64'd1);
    check("disc_b", 64'(resp_discard_o), 64'd1);
    step();
    check("cnt_zero", 64'(cancel_cnt_o), 64'd0);
    check("disc_c", 64'(resp_discard_o), 64'd0);
    step();
    check("cnt_zero_b", 64'(cancel_cnt_o), 64'd0);
    resp_valid_i = 0;

    // Saturation
    cancel_inc_i = 1;
    repeat (4) step();
    check("cnt_sat", 64'(cancel_cnt_o), 64'd3);
    check("ovf_set", 64'(cancel_ovf_o), 64'd1);
    resp_valid_i = 1;
    #1 check("disc_sat", 64'(resp_discard_o), 64'd1);
    step();
    check("cnt_sat_b", 64'(cancel_cnt_o), 64'd3);
    cancel_inc_i = 0;
    repeat (3) step();
    check("cnt_drain", 64'(cancel_cnt_o), 64'd0);
    resp_valid_i = 0;

    // Buffer
    resp_valid_i = 1; buf_hold_i = 1; resp_data_i = 64'hDEAD_BEEF_0000_0001;
    step();
    check("buf_fill", 64'(inst_buf_valid_o), 64'd1);
    check("buf_data", inst_buf_data_o, 64'hDEAD_BEEF_0000_0001);
    resp_data_i = 64'h1234_5678_9ABC_DEF0;
    step();
    check("buf_keep", inst_buf_data_o, 64'hDEAD_BEEF_0000_0001);
    buf_take_i = 1; resp_data_i = 64'h0BAD_F00D_0000_0002;
    step();
    check("buf_take", 64'(inst_buf_valid_o), 64'd0);
    idle();

`ifdef FETCH_DISCARD_STAT_EN
    // Six discards happened above; five more follow, then two kept responses.
    cancel_inc_i = 1; repeat (3) step();
    cancel_inc_i = 0; resp_valid_i = 1; repeat (3) step();
    resp_valid_i = 0; cancel_inc_i = 1; repeat (2) step();
    cancel_inc_i = 0; resp_valid_i = 1; repeat (2) step();
    repeat (2) step();
    resp_valid_i = 0;
    check("stat_total", 64'(discard_total_o), 64'd11);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      preif_valid_i  = ($urandom_range(0, 3) != 0);
      if_allowin_i   = ($urandom_range(0, 2) != 0);
      excep_flush_i  = ($urandom_range(0, 15) == 0);
      branch_flush_i = ($urandom_range(0, 15) == 0);
      req_i          = 1'($urandom);
      pc_i           = {$urandom, $urandom};
      exc_en_i       = LANES'($urandom);
      exc_type_i     = (LANES*EXC_W)'($urandom);
      pr_we_i        = 1'($urandom);
      pr_data_i      = {$urandom, $urandom};
      cancel_inc_i   = ($urandom_range(0, 2) == 0);
      resp_valid_i   = 1'($urandom);
      resp_data_i    = {$urandom, $urandom};
      buf_hold_i     = 1'($urandom);
      buf_take_i     = ($urandom_range(0, 3) == 0);
      step();
    end
    rst_n = 1;
    idle();
    step();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
